// File: rtl/gate_exerciser.sv
// Stimulus/check engine for a two-input gate: walks {a,b} through 00..11,
// samples the synchronized gate output and compares against a truth table.
module gate_exerciser #(
   parameter logic [3:0] EXPECT = 4'b0001,
   parameter int         SETTLE = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       dut_y,
   output logic       drv_a,
   output logic       drv_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [7:0] run_count
);

   typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

   state_t      state_q, state_d;
   logic [1:0]  vec_q, vec_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  sync_q;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [3:0]  fail_mask_q, fail_mask_d;
   logic [7:0]  run_count_q, run_count_d;
   logic        y_s;

   assign y_s = sync_q[1];

   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      fail_mask_d = fail_mask_q;
      run_count_d = run_count_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               vec_d       = 2'd0;
               cnt_d       = 8'd0;
               fail_mask_d = 4'd0;
               pass_d      = 1'b0;
               busy_d      = 1'b1;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               vec_d   = 2'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               vec_d   = 2'd0;
            end else begin
               if (y_s != EXPECT[vec_q]) fail_mask_d[vec_q] = 1'b1;
               if (vec_q == 2'd3) begin
                  // Results land with the last sample so they are final when done is seen.
                  state_d = DONE;
                  done_d  = 1'b1;
                  pass_d  = (fail_mask_d == 4'd0);
                  vec_d   = 2'd0;
                  if (run_count_q != 8'hFF) run_count_d = run_count_q + 8'd1;
               end else begin
                  vec_d   = vec_q + 2'd1;
                  cnt_d   = 8'd0;
                  state_d = WAIT;
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vec_q       <= 2'd0;
         cnt_q       <= 8'd0;
         sync_q      <= 2'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_mask_q <= 4'd0;
         run_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         cnt_q       <= cnt_d;
         sync_q      <= {sync_q[0], dut_y};
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_mask_q <= fail_mask_d;
         run_count_q <= run_count_d;
      end
   end

   assign drv_a     = vec_q[1];
   assign drv_b     = vec_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = fail_mask_q;
   assign run_count = run_count_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Scoreboard bench for gate_exerciser: each run pushes its expected done edge
// and results; a negedge monitor pops and compares whenever done pulses.
module tb_gate_exerciser;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       dut_y;
   logic       drv_a, drv_b, busy, done, pass;
   logic [3:0] fail_mask;
   logic [7:0] run_count;

   // 0 = NOR, 1 = OR, 2 = stuck at 0, 3 = stuck at 1
   int mode = 0;
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         edge_n;
      logic       pass;
      logic [3:0] mask;
      logic [7:0] rc;
   } exp_t;
   exp_t q[$];

   gate_exerciser dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_y(dut_y),
      .drv_a(drv_a), .drv_b(drv_b), .busy(busy), .done(done), .pass(pass),
      .fail_mask(fail_mask), .run_count(run_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      case (mode)
         0:       dut_y = ~(drv_a | drv_b);
         1:       dut_y = drv_a | drv_b;
         2:       dut_y = 1'b0;
         default: dut_y = 1'b1;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done at edge %0d", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("done_edge", cyc, e.edge_n);
            chk("pass", {31'd0, pass}, {31'd0, e.pass});
            chk("fail_mask", {28'd0, fail_mask}, {28'd0, e.mask});
            chk("run_count", {24'd0, run_count}, {24'd0, e.rc});
         end
      end
   end

   task automatic start_run(output int s, input logic with_abort);
      @(negedge clk);
      start = 1'b1;
      abort = with_abort;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      s = cyc;
   endtask

   task automatic wait_to(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((q.size() != 0 || busy) && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 200) begin
         errors++;
         $display("FAIL idle_timeout actual pending %0d expected 0", q.size());
      end
   endtask

   initial begin
      int s;
      repeat (2) @(negedge clk);
      chk("reset_outs", {16'd0, drv_a, drv_b, busy, done, pass, fail_mask, run_count}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Ideal NOR: full pass, drive sequence timing
      mode = 0;
      start_run(s, 1'b0);
      q.push_back('{s + 20, 1'b1, 4'b0000, 8'd1});
      chk("busy_at_s", {31'd0, busy}, 32'd1);
      chk("drv_s0", {30'd0, drv_a, drv_b}, 32'd0);
      wait_to(s + 5);
      chk("drv_s5", {30'd0, drv_a, drv_b}, 32'd1);
      wait_to(s + 10);
      chk("drv_s10", {30'd0, drv_a, drv_b}, 32'd2);
      wait_to(s + 15);
      chk("drv_s15", {30'd0, drv_a, drv_b}, 32'd3);
      wait_to(s + 20);
      chk("drv_done", {30'd0, drv_a, drv_b}, 32'd0);
      wait_idle();

      mode = 1;
      start_run(s, 1'b0);
      q.push_back('{s + 20, 1'b0, 4'b1111, 8'd2});
      wait_idle();

      mode = 2;
      start_run(s, 1'b0);
      q.push_back('{s + 20, 1'b0, 4'b0001, 8'd3});
      wait_idle();

      // Stuck at 1, with abort raised alongside start in IDLE (start wins)
      mode = 3;
      start_run(s, 1'b1);
      q.push_back('{s + 20, 1'b0, 4'b1110, 8'd4});
      wait_idle();

      // start re-pulsed mid-run, then held through done
      mode = 0;
      start_run(s, 1'b0);
      q.push_back('{s + 20, 1'b1, 4'b0000, 8'd5});
      q.push_back('{s + 42, 1'b1, 4'b0000, 8'd6});
      wait_to(s + 2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_to(s + 11);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_to(s + 14);
      start = 1'b1;
      wait_to(s + 21);
      chk("busy_fall", {31'd0, busy}, 32'd0);
      wait_to(s + 22);
      chk("busy_rerun", {31'd0, busy}, 32'd1);
      start = 1'b0;
      wait_idle();

      // Abort during vector 1 with OR model
      mode = 1;
      start_run(s, 1'b0);
      wait_to(s + 6);
      abort = 1'b1;
      wait_to(s + 7);
      abort = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_drv", {30'd0, drv_a, drv_b}, 32'd0);
      repeat (25) @(negedge clk);
      chk("abort_res", {19'd0, busy, pass, fail_mask, run_count}, {19'd0, 1'b0, 1'b0, 4'b0001, 8'd6});

      // Asynchronous reset mid-run
      mode = 0;
      start_run(s, 1'b0);
      wait_to(s + 12);
      rst_n = 1'b0;
      #1;
      chk("midrun_reset", {16'd0, drv_a, drv_b, busy, done, pass, fail_mask, run_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      start_run(s, 1'b0);
      q.push_back('{s + 20, 1'b1, 4'b0000, 8'd1});
      wait_idle();

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
